// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 4;

  // Counter must hold the value WIDTH itself, hence w+1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One unsigned restoring-division iteration: shift, trial subtract, restore on borrow.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_shift;

  // The partial remainder is always below the divisor, so its top bit is
  // implicitly zero and only WIDTH bits need to be carried between steps.
  always_comb begin
    r_shift = {r, q[WIDTH-1]};
    q_shift = {q[WIDTH-2:0], 1'b0};
    trial   = r_shift - {1'b0, d};
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = q_shift | WIDTH'(1);
    end else begin
      r_next = r_shift[WIDTH-1:0];
      q_next = q_shift;
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_r, r_r, d_r;
  logic [WIDTH-1:0] q_step, r_step;
  logic             accept, zero_div, last;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_r),
    .q      (q_r),
    .d      (d_r),
    .r_next (r_step),
    .q_next (q_step)
  );

  always_comb begin
    accept   = 1'b0;
    zero_div = (divisor == '0);
    last     = (cnt == CW'(1));
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        accept   = start;
        state_nx = start ? (zero_div ? DONE : RUN) : IDLE;
      end
      RUN:     if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Result registers only change on entry to DONE, so the previous
  // operation's results stay visible while a new one runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      q_r         <= '0;
      r_r         <= '0;
      d_r         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
        cnt         <= '0;
      end else begin
        q_r         <= dividend;
        r_r         <= '0;
        d_r         <= divisor;
        cnt         <= CW'(WIDTH);
        div_by_zero <= 1'b0;
      end
    end else if (state == RUN) begin
      q_r <= q_step;
      r_r <= r_step;
      cnt <= cnt - CW'(1);
      if (last) begin
        quotient  <= q_step;
        remainder <= r_step;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: directed vectors plus full 4-bit operand sweep.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   dones  = 0;
  int   n_ops  = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      dones++;
      chk("busy_low_on_done", int'(busy), 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("quotient_%0d_%0d", e.a, e.b), int'(quotient), int'(e.q));
        chk($sformatf("remainder_%0d_%0d", e.a, e.b), int'(remainder), int'(e.r));
        chk($sformatf("dbz_%0d_%0d", e.a, e.b), int'(div_by_zero), int'(e.z));
        if (!e.z) begin
          chk("invariant", int'(quotient) * int'(e.b) + int'(remainder), int'(e.a));
          chk("rem_lt_div", int'(remainder < e.b), 1);
        end
      end
    end
  end

  task automatic issue(input int a, input int b, input int q, input int r, input int z);
    exp_t e;
    e.a = W'(a); e.b = W'(b); e.q = W'(q); e.r = W'(r); e.z = z[0];
    sb.push_back(e);
    n_ops++;
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcyc);
    cyc  = 0;
    bcyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      cyc++;
      if (done) return;
      if (busy) bcyc++;
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic run(input int a, input int b, input int q, input int r, input int z);
    int cyc, bcyc;
    issue(a, b, q, r, z);
    wait_done(cyc, bcyc);
    chk($sformatf("latency_%0d_%0d", a, b), cyc, z ? 1 : W + 1);
  endtask

  initial begin
    int cyc, bcyc;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    // 13/3 from IDLE with latency and busy duration
    issue(13, 3, 4, 1, 0);
    wait_done(cyc, bcyc);
    chk("latency_13_3", cyc, W + 1);
    chk("busy_cycles_13_3", bcyc, W);

    run(15, 1, 15, 0, 0);
    run(7, 9, 0, 7, 0);
    run(0, 5, 0, 0, 0);
    run(15, 15, 1, 0, 0);

    // divide by zero, then a normal op clears the flag while old results remain
    run(9, 0, 15, 9, 1);
    issue(8, 2, 4, 0, 0);
    @(negedge clk);
    chk("run_busy", int'(busy), 1);
    chk("run_keeps_quotient", int'(quotient), 15);
    chk("run_keeps_remainder", int'(remainder), 9);
    chk("run_dbz_cleared", int'(div_by_zero), 0);
    wait_done(cyc, bcyc);
    chk("latency_8_2", cyc + 1, W + 1);
    repeat (3) @(negedge clk);

    // start pulsed during RUN is ignored
    issue(13, 3, 4, 1, 0);
    @(posedge clk);
    #1 begin start = 1'b1; dividend = 4'd6; divisor = 4'd2; end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, bcyc);
    chk("latency_ignored_start", cyc, 3);
    repeat (4) @(negedge clk);
    chk("single_done", dones, n_ops);

    // reset abort mid-RUN
    issue(13, 3, 4, 1, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    sb.delete();
    n_ops--;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run(10, 4, 2, 2, 0);

    // back-to-back: start already high during the DONE cycle
    run(13, 3, 4, 1, 0);
    run(12, 5, 2, 2, 0);

    // full operand sweep against a reference model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) run(a, b, 15, a, 1);
        else        run(a, b, a / b, a % b, 0);
      end
    end

    repeat (3) @(negedge clk);
    chk("total_dones", dones, n_ops);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
